// File: rtl/approx_adder_eval_ctrl.sv
// Error-characterisation controller for approximate adders: LFSR operand generator plus error statistics.
// Optional macro EVAL_MAX_ERR_EN compiles in the err_max register and comparator; otherwise err_max is tied to 0.
module approx_adder_eval_ctrl #(
  parameter int unsigned W     = 16,
  parameter int unsigned CNT_W = 18,
  parameter int unsigned ACC_W = 40,
  parameter logic [31:0] SEED  = 32'hACE1_1234
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] n_vectors,
  output logic [W-1:0]     in1,
  output logic [W-1:0]     in2,
  input  logic [W:0]       res,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] err_count,
  output logic [ACC_W-1:0] err_sum,
  output logic [W:0]       err_max,
  output logic [CNT_W-1:0] vec_count
);

  localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [31:0] POLY     = 32'h8020_0003;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [31:0]      lfsr;
  logic [CNT_W-1:0] target;

  logic [W:0]       exact_c;
  logic [W:0]       abs_err_c;
  logic [31:0]      lfsr_nxt_c;
  logic [ACC_W:0]   sum_ext_c;
  logic [CNT_W-1:0] vec_nxt_c;
  logic             accept_c;
  logic             capture_c;
  logic             last_c;

  // Reference sum and magnitude of the adder-under-test error.
  assign exact_c    = (W+1)'(in1) + (W+1)'(in2);
  assign abs_err_c  = (res >= exact_c) ? (res - exact_c) : (exact_c - res);
  assign lfsr_nxt_c = (lfsr >> 1) ^ (lfsr[0] ? POLY : 32'h0);
  assign sum_ext_c  = (ACC_W+1)'(err_sum) + (ACC_W+1)'(abs_err_c);
  assign vec_nxt_c  = vec_count + CNT_W'(1);
  assign accept_c   = (state == IDLE) && start;
  assign capture_c  = (state == RUN);
  assign last_c     = (vec_nxt_c == target);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lfsr      <= SEED_EFF;
      target    <= '0;
      in1       <= '0;
      in2       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_count <= '0;
      err_sum   <= '0;
      vec_count <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            err_count <= '0;
            err_sum   <= '0;
            vec_count <= '0;
            if (n_vectors == '0) begin
              done <= 1'b1;
            end else begin
              lfsr   <= SEED_EFF;
              in1    <= SEED_EFF[W-1:0];
              in2    <= SEED_EFF[16+W-1:16];
              target <= n_vectors;
              busy   <= 1'b1;
              state  <= RUN;
            end
          end
        end
        RUN: begin
          vec_count <= vec_nxt_c;
          if (abs_err_c != '0) err_count <= err_count + CNT_W'(1);
          // Saturate the accumulator instead of wrapping.
          err_sum <= sum_ext_c[ACC_W] ? {ACC_W{1'b1}} : sum_ext_c[ACC_W-1:0];
          if (last_c) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            lfsr <= lfsr_nxt_c;
            in1  <= lfsr_nxt_c[W-1:0];
            in2  <= lfsr_nxt_c[16+W-1:16];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef EVAL_MAX_ERR_EN
  // Running maximum of the absolute error over the current run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_max <= '0;
    end else if (accept_c) begin
      err_max <= '0;
    end else if (capture_c && (abs_err_c > err_max)) begin
      err_max <= abs_err_c;
    end
  end
`else
  assign err_max = '0;
`endif

endmodule

// File: tb/tb_approx_adder_eval_ctrl.sv
// Scoreboard bench for approx_adder_eval_ctrl: behavioural adder models with a fixed per-vector error.
module tb_approx_adder_eval_ctrl;

  localparam int unsigned W     = 16;
  localparam int unsigned CNT_W = 18;
  localparam int unsigned ACC_W = 8;
  localparam longint      SUM_MAX = 255;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] n_vectors = '0;
  logic [W-1:0]     in1, in2;
  logic [W:0]       res;
  logic             busy, done;
  logic [CNT_W-1:0] err_count, vec_count;
  logic [ACC_W-1:0] err_sum;
  logic [W:0]       err_max;

  approx_adder_eval_ctrl #(.W(W), .CNT_W(CNT_W), .ACC_W(ACC_W), .SEED(32'hACE1_1234)) dut (
    .clk(clk), .rst(rst), .start(start), .n_vectors(n_vectors),
    .in1(in1), .in2(in2), .res(res), .busy(busy), .done(done),
    .err_count(err_count), .err_sum(err_sum), .err_max(err_max), .vec_count(vec_count)
  );

  always #5 clk = ~clk;

  // Adder-under-test models: 0 exact, 1 always one high, 2 always three away.
  int mode = 0;
  logic [W:0] exact;
  always_comb begin
    exact = {1'b0, in1} + {1'b0, in2};
    res   = exact;
    if (mode == 1) res = exact + 17'd1;
    else if (mode == 2) res = (exact >= 17'd3) ? exact - 17'd3 : exact + 17'd3;
  end

  typedef struct {
    int     done_cyc;
    longint vec;
    longint errs;
    longint sum;
    longint max;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] vec_q[$];
  logic [31:0] hand[4];
  int          cyc = 0;
  int          checks = 0;
  int          passed = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  // Monitor: pops expected operands while busy and expected statistics on done.
  always @(negedge clk) begin
    logic [31:0] v;
    exp_t e;
    if (busy) begin
      if (vec_q.size() == 0) chk("unexpected_vector", 1, 0);
      else begin
        v = vec_q.pop_front();
        chk("in1", in1, v[15:0]);
        chk("in2", in2, v[31:16]);
      end
    end
    if (done) begin
      if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("done_cycle", cyc, e.done_cyc);
        chk("busy_at_done", busy, 0);
        chk("vec_count", vec_count, e.vec);
        chk("err_count", err_count, e.errs);
        chk("err_sum", err_sum, e.sum);
        chk("err_max", err_max, e.max);
      end
    end
  end

  // Queue the expected vectors and final statistics, then pulse start.
  task automatic issue(input int n, input int e);
    exp_t x;
    logic [31:0] v;
    longint s;
    mode = (e == 0) ? 0 : (e == 1) ? 1 : 2;
    v = 32'hACE1_1234;
    for (int i = 0; i < n; i++) begin
      vec_q.push_back((i < 4) ? hand[i] : v);
      v = lfsr_step(v);
    end
    s = longint'(n) * longint'(e);
    x.vec  = n;
    x.errs = (e != 0) ? n : 0;
    x.sum  = (s > SUM_MAX) ? SUM_MAX : s;
`ifdef EVAL_MAX_ERR_EN
    x.max  = (n != 0) ? e : 0;
`else
    x.max  = 0;
`endif
    @(negedge clk);
    start = 1'b1;
    n_vectors = CNT_W'(n);
    @(posedge clk);
    #1;
    start = 1'b0;
    x.done_cyc = cyc + n;
    exp_q.push_back(x);
  endtask

  task automatic wait_done(input int bound);
    int k = 0;
    while (exp_q.size() != 0 && k < bound) begin
      @(negedge clk);
      #2;
      k++;
    end
    if (exp_q.size() != 0) begin
      chk("timeout_waiting_done", exp_q.size(), 0);
      exp_q.delete();
      vec_q.delete();
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_in1"}, in1, 0);
    chk({tag, "_in2"}, in2, 0);
    chk({tag, "_vec_count"}, vec_count, 0);
    chk({tag, "_err_count"}, err_count, 0);
    chk({tag, "_err_sum"}, err_sum, 0);
    chk({tag, "_err_max"}, err_max, 0);
  endtask

  initial begin
    hand[0] = 32'hACE1_1234;
    hand[1] = 32'h5670_891A;
    hand[2] = 32'h2B38_448D;
    hand[3] = 32'h95BC_2245;

    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    issue(1000, 0);  wait_done(1100);
    issue(10, 1);    wait_done(40);
    issue(100, 3);   wait_done(140);
    issue(0, 0);     wait_done(10);

    // Second start at capture 3 must be ignored.
    issue(10, 1);
    repeat (3) @(negedge clk);
    start = 1'b1;
    n_vectors = CNT_W'(5);
    @(negedge clk);
    start = 1'b0;
    wait_done(40);

    // Reset at capture 5 aborts the run with no done pulse.
    issue(10, 1);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk_all_zero("abort");
    exp_q.delete();
    vec_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    issue(3, 0);     wait_done(20);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
